// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, Funct codes,
// ALU control codes and datapath mux selects.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_R_EXE,
    S_R_WB, S_BEQ, S_IMM_EXE, S_IMM_WB, S_JUMP, S_ILLEGAL
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_IMM} aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       zero_ext;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// ALU decoder: maps the controller's ALUOp plus Op/Funct to an ALU control code.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);

  logic [2:0] funct_code;

  always_comb begin
    funct_code  = ALU_AND;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  funct_code = ALU_ADD;
      FN_SUB:  funct_code = ALU_SUB;
      FN_AND:  funct_code = ALU_AND;
      FN_OR:   funct_code = ALU_OR;
      FN_SLT:  funct_code = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (aluop)
      ALUOP_ADD:   alu_ctrl = ALU_ADD;
      ALUOP_SUB:   alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: alu_ctrl = funct_code;
      ALUOP_IMM: begin
        case (op)
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_SLTI: alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style main controller: Moore state decode (PC_Write also
// folds in the branch Zero term), with outputs held at 0 while reset is high.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W      = 3,
  parameter int ENABLE_EXT      = 1,
  parameter int TRAP_ON_ILLEGAL = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            Op,
  input  logic [5:0]            Funct,
  input  logic                  Zero,
  output logic                  PC_Write,
  output logic                  I_or_D,
  output logic                  Mem_Write,
  output logic                  IR_Write,
  output logic                  Reg_Dst,
  output logic                  Mem_to_Reg,
  output logic                  Reg_Write,
  output logic                  ALU_Src_A,
  output logic [1:0]            ALU_Src_B,
  output logic [ALU_CTRL_W-1:0] ALU_Control,
  output logic [1:0]            PC_Src,
  output logic                  Zero_Ext,
  output logic                  Illegal
);

  state_t     state, state_nx;
  ctrl_t      ctrl;
  aluop_t     aluop;
  logic       alu_en;
  logic [2:0] alu_code;
  logic       funct_ok;
  logic       ext_ok;
  logic       imm_logic;

  assign ext_ok    = (ENABLE_EXT != 0);
  assign imm_logic = (Op == OP_ANDI) || (Op == OP_ORI);

  alu_decoder u_alu_dec (
    .aluop      (aluop),
    .op         (Op),
    .funct      (Funct),
    .alu_ctrl   (alu_code),
    .funct_valid(funct_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ctrl     = '0;
    aluop    = ALUOP_ADD;
    alu_en   = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.pc_write  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_src    = PCSRC_ALU;
        alu_en         = 1'b1;
        state_nx       = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        alu_en         = 1'b1;
        case (Op)
          OP_LW, OP_SW:              state_nx = S_MEM_ADR;
          OP_RTYPE:                  state_nx = S_R_EXE;
          OP_BEQ:                    state_nx = S_BEQ;
          OP_ADDI:                   state_nx = S_IMM_EXE;
          OP_ANDI, OP_ORI, OP_SLTI:  state_nx = ext_ok ? S_IMM_EXE : S_ILLEGAL;
          OP_J:                      state_nx = ext_ok ? S_JUMP : S_ILLEGAL;
          default:                   state_nx = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        alu_en         = 1'b1;
        state_nx       = (Op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        ctrl.i_or_d = 1'b1;
        state_nx    = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_nx        = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_write = 1'b1;
        state_nx       = S_FETCH;
      end
      S_R_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        aluop          = ALUOP_FUNCT;
        alu_en         = 1'b1;
        state_nx       = funct_ok ? S_R_WB : S_ILLEGAL;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_nx       = S_FETCH;
      end
      S_BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_write  = Zero;
        aluop          = ALUOP_SUB;
        alu_en         = 1'b1;
        state_nx       = S_FETCH;
      end
      S_IMM_EXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.zero_ext  = imm_logic;
        aluop          = ALUOP_IMM;
        alu_en         = 1'b1;
        state_nx       = S_IMM_WB;
      end
      S_IMM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.zero_ext  = imm_logic;
        state_nx       = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
        state_nx      = S_FETCH;
      end
      S_ILLEGAL: begin
        ctrl.illegal = 1'b1;
        state_nx     = (TRAP_ON_ILLEGAL != 0) ? S_ILLEGAL : S_FETCH;
      end
      default: state_nx = S_FETCH;
    endcase
  end

  // Reset gates every output combinationally so nothing leaks during reset.
  always_comb begin
    PC_Write    = 1'b0;
    I_or_D      = 1'b0;
    Mem_Write   = 1'b0;
    IR_Write    = 1'b0;
    Reg_Dst     = 1'b0;
    Mem_to_Reg  = 1'b0;
    Reg_Write   = 1'b0;
    ALU_Src_A   = 1'b0;
    ALU_Src_B   = 2'b00;
    ALU_Control = '0;
    PC_Src      = 2'b00;
    Zero_Ext    = 1'b0;
    Illegal     = 1'b0;
    if (!reset) begin
      PC_Write    = ctrl.pc_write;
      I_or_D      = ctrl.i_or_d;
      Mem_Write   = ctrl.mem_write;
      IR_Write    = ctrl.ir_write;
      Reg_Dst     = ctrl.reg_dst;
      Mem_to_Reg  = ctrl.mem_to_reg;
      Reg_Write   = ctrl.reg_write;
      ALU_Src_A   = ctrl.alu_src_a;
      ALU_Src_B   = ctrl.alu_src_b;
      ALU_Control = alu_en ? ALU_CTRL_W'(alu_code) : '0;
      PC_Src      = ctrl.pc_src;
      Zero_Ext    = ctrl.zero_ext;
      Illegal     = ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: three parameterizations checked cycle by cycle
// against an instruction-level model of the control sequence.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst;
  logic [5:0] op, funct;
  logic       zero;
  int checks = 0;
  int failures = 0;

  // index 0: defaults, 1: trapping, 2: no extensions with 4-bit ALU_Control
  logic pcw [3], iord [3], memw [3], irw [3], rdst [3], m2r [3], rw [3], sa [3], ze [3], ill [3];
  logic [1:0] sb [3], ps [3];
  logic [2:0] alu_m, alu_t;
  logic [3:0] alu_e;

  mc_control_fsm u_main (
    .clk(clk), .reset(rst[0]), .Op(op), .Funct(funct), .Zero(zero),
    .PC_Write(pcw[0]), .I_or_D(iord[0]), .Mem_Write(memw[0]), .IR_Write(irw[0]),
    .Reg_Dst(rdst[0]), .Mem_to_Reg(m2r[0]), .Reg_Write(rw[0]), .ALU_Src_A(sa[0]),
    .ALU_Src_B(sb[0]), .ALU_Control(alu_m), .PC_Src(ps[0]), .Zero_Ext(ze[0]), .Illegal(ill[0]));

  mc_control_fsm #(.TRAP_ON_ILLEGAL(1)) u_trap (
    .clk(clk), .reset(rst[1]), .Op(op), .Funct(funct), .Zero(zero),
    .PC_Write(pcw[1]), .I_or_D(iord[1]), .Mem_Write(memw[1]), .IR_Write(irw[1]),
    .Reg_Dst(rdst[1]), .Mem_to_Reg(m2r[1]), .Reg_Write(rw[1]), .ALU_Src_A(sa[1]),
    .ALU_Src_B(sb[1]), .ALU_Control(alu_t), .PC_Src(ps[1]), .Zero_Ext(ze[1]), .Illegal(ill[1]));

  mc_control_fsm #(.ENABLE_EXT(0), .ALU_CTRL_W(4)) u_ext (
    .clk(clk), .reset(rst[2]), .Op(op), .Funct(funct), .Zero(zero),
    .PC_Write(pcw[2]), .I_or_D(iord[2]), .Mem_Write(memw[2]), .IR_Write(irw[2]),
    .Reg_Dst(rdst[2]), .Mem_to_Reg(m2r[2]), .Reg_Write(rw[2]), .ALU_Src_A(sa[2]),
    .ALU_Src_B(sb[2]), .ALU_Control(alu_e), .PC_Src(ps[2]), .Zero_Ext(ze[2]), .Illegal(ill[2]));

  function automatic logic [17:0] get_obs(int w);
    logic [3:0] a;
    a = (w == 0) ? {1'b0, alu_m} : (w == 1) ? {1'b0, alu_t} : alu_e;
    return {pcw[w], iord[w], memw[w], irw[w], rdst[w], m2r[w], rw[w], sa[w], sb[w], a, ps[w], ze[w], ill[w]};
  endfunction

  // ---- reference model: instruction -> list of steps, step -> control vector
  typedef string sq_t[$];

  function automatic logic funct_defined(logic [5:0] f);
    return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic sq_t instr_seq(logic [5:0] o, logic [5:0] f, bit ext);
    sq_t q;
    q.push_back("FETCH");
    q.push_back("DECODE");
    case (o)
      6'b100011: begin q.push_back("MEM_ADR"); q.push_back("MEM_RD"); q.push_back("MEM_WB"); end
      6'b101011: begin q.push_back("MEM_ADR"); q.push_back("MEM_WR"); end
      6'b000000: begin q.push_back("R_EXE"); q.push_back(funct_defined(f) ? "R_WB" : "ILLEGAL"); end
      6'b000100: q.push_back("BEQ");
      6'b001000: begin q.push_back("IMM_EXE"); q.push_back("IMM_WB"); end
      6'b001100, 6'b001101, 6'b001010: begin
        if (ext) begin q.push_back("IMM_EXE"); q.push_back("IMM_WB"); end
        else q.push_back("ILLEGAL");
      end
      6'b000010: q.push_back(ext ? "JUMP" : "ILLEGAL");
      default: q.push_back("ILLEGAL");
    endcase
    return q;
  endfunction

  function automatic logic [17:0] exp_out(string s, logic [5:0] o, logic [5:0] f, logic z);
    logic p_w, i_d, m_w, i_w, r_d, m_r, r_w, s_a, z_e, il;
    logic [1:0] s_b, p_s;
    logic [3:0] a;
    {p_w, i_d, m_w, i_w, r_d, m_r, r_w, s_a, z_e, il} = '0;
    s_b = 2'b00; p_s = 2'b00; a = 4'd0;
    case (s)
      "FETCH":   begin p_w = 1; i_w = 1; s_b = 2'b01; a = 4'b0010; end
      "DECODE":  begin s_b = 2'b11; a = 4'b0010; end
      "MEM_ADR": begin s_a = 1; s_b = 2'b10; a = 4'b0010; end
      "MEM_RD":  i_d = 1;
      "MEM_WB":  begin r_w = 1; m_r = 1; end
      "MEM_WR":  begin i_d = 1; m_w = 1; end
      "R_EXE": begin
        s_a = 1;
        case (f)
          6'b100000: a = 4'b0010;
          6'b100010: a = 4'b0110;
          6'b100100: a = 4'b0000;
          6'b100101: a = 4'b0001;
          6'b101010: a = 4'b0111;
          default:   a = 4'b0000;
        endcase
      end
      "R_WB":    begin r_w = 1; r_d = 1; end
      "BEQ":     begin s_a = 1; a = 4'b0110; p_s = 2'b01; p_w = z; end
      "IMM_EXE": begin
        s_a = 1; s_b = 2'b10;
        a = (o == 6'b001100) ? 4'b0000 : (o == 6'b001101) ? 4'b0001 : (o == 6'b001010) ? 4'b0111 : 4'b0010;
        z_e = (o == 6'b001100) || (o == 6'b001101);
      end
      "IMM_WB":  begin r_w = 1; z_e = (o == 6'b001100) || (o == 6'b001101); end
      "JUMP":    begin p_s = 2'b10; p_w = 1; end
      "ILLEGAL": il = 1;
      default: ;
    endcase
    return {p_w, i_d, m_w, i_w, r_d, m_r, r_w, s_a, s_b, a, p_s, z_e, il};
  endfunction

  // ---- stimulus helpers
  task automatic check(input int w, input string tag, input logic [17:0] e);
    logic [17:0] o;
    o = get_obs(w);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge with the instance in FETCH.
  task automatic run_instr(input int w, input string tag, input logic [5:0] o,
                           input logic [5:0] f, input logic z);
    sq_t q;
    q = instr_seq(o, f, w != 2);
    op = o; funct = f; zero = z;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      check(w, $sformatf("%s:c%0d:%s", tag, i + 1, q[i]), exp_out(q[i], o, f, z));
      tick();
    end
  endtask

  task automatic do_reset(input int w, input int n);
    rst[w] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(w, $sformatf("reset_zero%0d_c%0d", w, i), 18'd0);
      tick();
    end
    rst[w] = 1'b0;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] tbl [10];
    tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
            6'b001100, 6'b001101, 6'b001010, 6'b000010, 6'b000000};
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    return tbl[$urandom_range(0, 9)];
  endfunction

  function automatic logic [5:0] rand_funct();
    logic [5:0] tbl [5];
    tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    if ($urandom_range(0, 4) == 0) return 6'($urandom_range(0, 63));
    return tbl[$urandom_range(0, 4)];
  endfunction

  initial begin
    rst = 3'b111; op = '0; funct = '0; zero = 1'b0;
    do_reset(0, 2);
    check(1, "trap_held_in_reset", 18'd0);

    run_instr(0, "addi", 6'b001000, 6'b000000, 1'b0);
    run_instr(0, "sub", 6'b000000, 6'b100010, 1'b0);
    run_instr(0, "beq_taken", 6'b000100, 6'b000000, 1'b1);
    run_instr(0, "beq_not", 6'b000100, 6'b000000, 1'b0);
    run_instr(0, "lw", 6'b100011, 6'b000000, 1'b0);
    run_instr(0, "sw", 6'b101011, 6'b000000, 1'b0);
    run_instr(0, "andi", 6'b001100, 6'b000000, 1'b0);
    run_instr(0, "ori", 6'b001101, 6'b000000, 1'b0);
    run_instr(0, "slti", 6'b001010, 6'b000000, 1'b0);
    run_instr(0, "j", 6'b000010, 6'b000000, 1'b0);
    run_instr(0, "r_badfunct", 6'b000000, 6'b111111, 1'b0);
    run_instr(0, "illegal_op", 6'b111111, 6'b000000, 1'b0);
    for (int i = 0; i < 60; i++)
      run_instr(0, $sformatf("rnd%0d", i), rand_op(), rand_funct(), 1'($urandom_range(0, 1)));

    // reset landing in the middle of a load
    op = 6'b100011; funct = '0; zero = 1'b0;
    begin
      string st [4];
      st = '{"FETCH", "DECODE", "MEM_ADR", "MEM_RD"};
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check(0, {"lw_cut:", st[i]}, exp_out(st[i], op, funct, zero));
        if (i < 3) tick();
      end
    end
    rst[0] = 1'b1;
    tick();
    @(negedge clk);
    check(0, "lw_cut:outputs_zero", 18'd0);
    tick();
    rst[0] = 1'b0;
    run_instr(0, "after_cut", 6'b000100, 6'b000000, 1'b1);
    rst[0] = 1'b1;

    // trapping instance
    rst[1] = 1'b0;
    run_instr(1, "trap_addi", 6'b001000, 6'b000000, 1'b0);
    op = 6'b111111;
    @(negedge clk); check(1, "trap:FETCH", exp_out("FETCH", op, funct, zero)); tick();
    @(negedge clk); check(1, "trap:DECODE", exp_out("DECODE", op, funct, zero)); tick();
    for (int i = 0; i < 12; i++) begin
      op = 6'($urandom_range(0, 63));
      @(negedge clk);
      check(1, $sformatf("trap:sticky%0d", i), exp_out("ILLEGAL", op, funct, zero));
      tick();
    end
    do_reset(1, 1);
    run_instr(1, "trap_after_reset", 6'b100011, 6'b000000, 1'b0);
    rst[1] = 1'b1;

    // extensions disabled, wide ALU_Control
    rst[2] = 1'b0;
    run_instr(2, "noext_j", 6'b000010, 6'b000000, 1'b0);
    run_instr(2, "noext_andi", 6'b001100, 6'b000000, 1'b0);
    run_instr(2, "noext_addi", 6'b001000, 6'b000000, 1'b0);
    run_instr(2, "noext_slt", 6'b000000, 6'b101010, 1'b0);
    for (int i = 0; i < 25; i++)
      run_instr(2, $sformatf("noext_rnd%0d", i), rand_op(), rand_funct(), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter ALU_CTRL_W, default 3: ALU_Control width; SHALL be >=3, with the upper bits driven 0.
REQ-002 Parameter ENABLE_EXT, default 1: 1 enables ANDI/ORI/SLTI/J; 0 treats those opcodes as illegal.
REQ-003 Parameter TRAP_ON_ILLEGAL, default 0: 1 makes the illegal-op state sticky until reset; 0 returns to FETCH after one cycle.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 Op  in  6  instruction opcode.
REQ-008 Funct  in  6  R-type function field.
REQ-009 Zero  in  1  ALU zero flag.
REQ-010 PC_Write  out  1  PC enable, including the taken-branch term.
REQ-011 I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write, ALU_Src_A  out  1 each  datapath controls.
REQ-012 ALU_Src_B  out  2  00 RegB, 01 const 4, 10 SignImm, 11 SignImm<<2.
REQ-013 ALU_Control  out  ALU_CTRL_W  codes: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-014 PC_Src  out  2  00 ALUResult, 01 ALUOut, 10 jump target.
REQ-015 Zero_Ext  out  1  1 selects a zero-extended immediate.
REQ-016 Illegal  out  1  high while in state ILLEGAL.

Function
REQ-017 States SHALL be: FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EXE, R_WB, BEQ, IMM_EXE, IMM_WB, JUMP, ILLEGAL.
REQ-018 Each state SHALL last exactly one clk cycle, and the outputs SHALL be a Moore decode of the state, except PC_Write.
REQ-019 FETCH SHALL assert IR_Write=1 and PC_Write=1, with ALU_Src_A=0, ALU_Src_B=01, ALU add, and PC_Src=00; the next state is DECODE.
REQ-020 DECODE SHALL drive ALU_Src_A=0, ALU_Src_B=11, and ALU add, and SHALL branch on Op: 100011/101011 -> MEM_ADR; 000000 -> R_EXE; 000100 -> BEQ; 001000/001100/001101/001010 -> IMM_EXE; 000010 -> JUMP; any other opcode -> ILLEGAL.
REQ-021 MEM_ADR SHALL drive ALU_Src_A=1, ALU_Src_B=10, and ALU add; the next state is MEM_RD for lw and MEM_WR for sw.
REQ-022 MEM_RD SHALL drive I_or_D=1 and go to MEM_WB.
REQ-023 MEM_WB SHALL drive Reg_Write=1, Mem_to_Reg=1, and Reg_Dst=0, then go to FETCH.
REQ-024 MEM_WR SHALL drive I_or_D=1 and Mem_Write=1, then go to FETCH.
REQ-025 R_EXE SHALL drive ALU_Src_A=1 and ALU_Src_B=00, with ALU_Control from Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
REQ-026 An R-type with an undefined Funct SHALL go to ILLEGAL at the R_EXE exit; a defined Funct SHALL go to R_WB.
REQ-027 R_WB SHALL drive Reg_Write=1, Reg_Dst=1, and Mem_to_Reg=0, then go to FETCH.
REQ-028 BEQ SHALL drive ALU_Src_A=1, ALU_Src_B=00, ALU sub, and PC_Src=01, with PC_Write=Zero; the next state is FETCH.
REQ-029 IMM_EXE SHALL drive ALU_Src_A=1 and ALU_Src_B=10, with the ALU operation per opcode: addi add, andi and, ori or, slti slt.
REQ-030 Zero_Ext SHALL be 1 for andi/ori in both IMM_EXE and IMM_WB; the next state after IMM_EXE is IMM_WB.
REQ-031 IMM_WB SHALL drive Reg_Write=1, Reg_Dst=0, and Mem_to_Reg=0, keeping Zero_Ext as set in REQ-030, then go to FETCH.
REQ-032 JUMP SHALL drive PC_Src=10 and PC_Write=1, then go to FETCH.
REQ-033 ILLEGAL SHALL assert Illegal=1 with all write enables 0; the next state is ILLEGAL if TRAP_ON_ILLEGAL=1, else FETCH.
REQ-034 Every control not listed for a state SHALL be 0.
REQ-035 Op and Funct SHALL be sampled combinationally in the states that use them; the block holds no instruction register.
REQ-036 Latency in cycles SHALL be: lw 5, sw 4, R-type 4, immediate 4, beq 3, j 3.

Reset
REQ-037 When reset=1 at a rising clk edge, the state SHALL become FETCH, regardless of the current state, including mid-instruction and ILLEGAL.
REQ-038 While reset=1, all outputs SHALL be forced to 0.
REQ-039 The first FETCH outputs SHALL appear in the first cycle after reset is sampled low.

Structure
REQ-040 Package mc_ctrl_pkg SHALL hold the state enumeration, the opcode and Funct constants, the ALU_Control codes, and the ALU_Src_B and PC_Src encodings.
REQ-041 There SHALL be one sub-module, alu_decoder, mapping an internal 2-bit ALUOp (add/sub/funct/imm) plus Op and Funct to ALU_Control and a funct-valid flag.

Verification
REQ-042 The bench SHALL cover: reset=1 for 2 cycles, then Op=001000 -> states FETCH, DECODE, IMM_EXE, IMM_WB; Reg_Write=1 only in cycle 4; ALU_Control=010 in IMM_EXE.
REQ-043 The bench SHALL cover: Op=000000, Funct=100010 -> R_EXE with ALU_Control=110, then R_WB with Reg_Write=1 and Reg_Dst=1; FETCH returns at cycle 5.
REQ-044 The bench SHALL cover: Op=000100 with Zero=1, then repeated with Zero=0 -> in the BEQ cycle, PC_Write is 1 and then 0, and PC_Src=01 in both cases.
REQ-045 The bench SHALL cover: Op=100011 -> 5 cycles with Mem_to_Reg=1 and Reg_Write=1 in MEM_WB; then Op=101011 -> Mem_Write=1 in the 4th cycle.
REQ-046 The bench SHALL cover: Op=111111 with TRAP_ON_ILLEGAL=1 -> Illegal stays 1 for 10 or more cycles; reset clears it and FETCH follows; with ENABLE_EXT=0, Op=000010 -> Illegal=1 in the 3rd cycle.
REQ-047 The bench SHALL cover: reset asserted in MEM_RD -> all outputs 0 in the next cycle, and FETCH follows after reset deasserts.
